// File: rtl/bcd_game_timer.sv
// N-digit BCD game timer: prescaled count-up/countdown with pause, clamped preset
// load, sticky expiry and wrap/saturate overflow reporting.
module bcd_game_timer #(
   parameter int NUM_DIGITS = 3,
   parameter int TICK_DIV   = 5000000,
   parameter bit SATURATE   = 1'b0
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst,
   input  logic                    i_Enable,
   input  logic                    i_Pause,
   input  logic                    i_Mode,
   input  logic [4*NUM_DIGITS-1:0] i_Load,
   output logic [4*NUM_DIGITS-1:0] o_Digits,
   output logic                    o_Tick,
   output logic                    o_Expired,
   output logic                    o_Overflow
);

   localparam int W  = 4 * NUM_DIGITS;
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] TERM  = PW'(TICK_DIV - 1);
   localparam logic [W-1:0]  NINES = {NUM_DIGITS{4'h9}};

   logic [PW-1:0] presc;
   logic [W-1:0]  digits;
   logic [W-1:0]  inc_val;
   logic [W-1:0]  dec_val;
   logic          tick;
   logic          expired;
   logic          overflow;

   // Ripple increment: a digit only moves when every lower digit was 9.
   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         carry;
      r     = v;
      carry = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (carry) begin
            if (v[4*k +: 4] >= 4'd9) begin
               r[4*k +: 4] = 4'd0;
            end else begin
               r[4*k +: 4] = v[4*k +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (borrow) begin
            if (v[4*k +: 4] == 4'd0) begin
               r[4*k +: 4] = 4'd9;
            end else begin
               r[4*k +: 4] = v[4*k +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Preset nibbles above 9 are forced to 9 so the digits never hold A..F.
   function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (v[4*k +: 4] > 4'd9) r[4*k +: 4] = 4'd9;
      end
      return r;
   endfunction

   assign inc_val = bcd_inc(digits);
   assign dec_val = bcd_dec(digits);

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         presc    <= '0;
         digits   <= '0;
         tick     <= 1'b0;
         expired  <= 1'b0;
         overflow <= 1'b0;
      end else if (!i_Enable) begin
         presc    <= '0;
         tick     <= 1'b0;
         expired  <= 1'b0;
         overflow <= 1'b0;
         digits   <= i_Mode ? bcd_clamp(i_Load) : '0;
      end else if (i_Pause || presc != TERM) begin
         // Non-step cycle: the wrap-mode overflow pulse ends, sticky flags hold.
         if (!i_Pause) presc <= presc + 1'b1;
         tick <= 1'b0;
         if (!SATURATE) overflow <= 1'b0;
      end else begin
         presc <= '0;
         tick  <= 1'b1;
         if (!i_Mode) begin
            if (digits == NINES) begin
               overflow <= 1'b1;
               if (!SATURATE) digits <= '0;
            end else begin
               digits <= inc_val;
               if (!SATURATE) overflow <= 1'b0;
            end
         end else begin
            if (!SATURATE) overflow <= 1'b0;
            if (digits == '0) begin
               expired <= 1'b1;
            end else begin
               digits <= dec_val;
               if (dec_val == '0) expired <= 1'b1;
            end
         end
      end
   end

   assign o_Digits   = digits;
   assign o_Tick     = tick;
   assign o_Expired  = expired;
   assign o_Overflow = overflow;

endmodule

// File: doc/bcd_game_timer.md
# bcd_game_timer

Parametrised BCD game timer with count-up and countdown modes, pause, preset load and expiry/overflow flags. It generalises the fixed three-digit seconds counter used on the maze HUD. It drives an N-digit seven-segment display and supplies the game FSM with a time-limit expiry indication. It sits between the game control FSM and the display multiplexer.

## Interface
- NUM_DIGITS, 3, number of BCD digits (1..8); digit 0 is least significant
- TICK_DIV, 5000000, i_Clk cycles per count step (≥2); default gives 20 steps/s at 100 MHz
- SATURATE, 0, count-up at all-9s: 0 = wrap to 0, 1 = hold at all-9s

Ports:
- i_Clk  in  1  system clock; all state changes on rising edge
- i_Rst  in  1  asynchronous, active-low reset
- i_Enable  in  1  0 = timer idle, held at start value; 1 = run
- i_Pause  in  1  1 = freeze digits and prescaler (only while i_Enable=1)
- i_Mode  in  1  0 = count up, 1 = count down
- i_Load  in  4*NUM_DIGITS  BCD countdown start value; nibble k = digit k
- o_Digits  out  4*NUM_DIGITS  current BCD value; nibble k = digit k
- o_Tick  out  1  one-cycle pulse on every edge where a count step is taken
- o_Expired  out  1  sticky: countdown reached zero
- o_Overflow  out  1  pulse (SATURATE=0) or sticky (SATURATE=1): up-count passed all-9s

## Operation
- Prescaler: $clog2(TICK_DIV)-bit counter. A step is taken when i_Enable=1, i_Pause=0 and prescaler==TICK_DIV-1; prescaler then returns to 0, otherwise it increments.
- Idle (i_Enable=0), evaluated every cycle:
  - prescaler=0
  - o_Expired=0, o_Overflow=0
  - o_Digits=0 when i_Mode=0, else o_Digits=i_Load with each nibble >9 clamped to 9
- Pause: digits, prescaler and flags hold. o_Tick=0.
- Count-up step:
  - BCD ripple increment: digit k rolls 9→0 and carries into k+1 only if digits 0..k-1 are all 9.
  - At all-9s with SATURATE=0: digits wrap to all-0 and o_Overflow pulses for that cycle.
  - At all-9s with SATURATE=1: digits hold and o_Overflow sets and stays set until idle.
- Count-down step:
  - BCD ripple decrement: digit k goes 0→9 and borrows from k+1 only if digits 0..k-1 are all 0.
  - If the value is already 0, digits hold and o_Expired sets.
  - If the step produces 0, o_Expired sets on that same edge.
  - o_Expired stays set until idle.
- i_Mode change while running takes effect at the next step; digits are not reloaded. Any value is valid in either direction.
- Digits are always legal BCD (0..9). Internal carry/borrow chains never produce A..F.
- i_Load is sampled only while idle. Changes while running are ignored.

## Timing
- Reset (async assert, sync-to-clock release): o_Digits=0, prescaler=0, o_Tick=0, o_Expired=0, o_Overflow=0.
- All outputs are registered. o_Tick, o_Digits and the flags change on the same edge.
- Enable rising: the first step occurs on the TICK_DIV-th rising edge with i_Enable=1 and i_Pause=0. Steps then repeat every TICK_DIV unpaused cycles.
- Pause inserts delay cycle-for-cycle. The prescaler phase is kept across pause, so cycles counted before the pause are not lost.
- Enable deasserted mid-count: idle values appear on the next edge. Re-enable restarts a full TICK_DIV period.
- Reset asserted mid-count: immediate return to reset values regardless of clock.
- Simultaneous i_Pause=1 and a terminal prescaler count: no step is taken; the step occurs on the first unpaused cycle.

## Test plan
- Up count (NUM_DIGITS=3, TICK_DIV=4, SATURATE=0):
  - Enable for 4000 cycles.
  - Required: o_Tick every 4th cycle; digits 000→001…→009→010; 999→000 with one o_Overflow pulse at cycle 4000.
- Countdown (i_Mode=1, i_Load=12'h012):
  - Enable.
  - Required: sequence 012, 011, 010, 009 … 001, 000. o_Expired sets on the edge producing 000 (cycle 48), stays 1, digits hold at 000.
- Load clamp and idle:
  - i_Enable=0, i_Mode=1, i_Load=12'hA5F.
  - Required: o_Digits=12'h959. After an enable/disable cycle, o_Expired clears and o_Digits returns to 959.
- Pause:
  - Enable, pause after 2 cycles for 10 cycles, then release.
  - Required: first o_Tick 2 cycles after release (cycle 14); value 001.
- Saturation (SATURATE=1, start up-count near top):
  - Run until digits reach 999, then continue running.
  - Required: digits hold at 999, o_Overflow=1 steady until i_Enable=0.
- Async reset mid-count:
  - Assert i_Rst=0 between clock edges while o_Digits=047.
  - Required: all outputs 0 immediately. After release, up-count resumes from 000 with a full TICK_DIV period.
